change_dispenser: RTL and testbench

- Payout end of the vending-machine coin path: accepts a change amount from the vending controller and drives a two-tube coin hopper, one coin per handshake, until the amount is paid.
- Payout is greedy: large coin (M2) first, then small coin (M1).
- Tracks per-tube coin stock, reports any unpaid remainder, and flags a jammed hopper through a timeout.

---
 rtl/change_dispenser_if.sv | 40 ++++
 rtl/change_dispenser.sv | 177 +++++++++++++++++
 tb/tb_change_dispenser.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/change_dispenser_if.sv
`default_nettype none
// ============================================================================
// Module      : change_dispenser_if
// Description : Payout bus between the vending controller / coin hopper side
//               (master) and the change dispenser (slave).
//               master -> slave : req, amount, hop_ack, refill_m1, refill_m2
//               slave -> master : eject_m1, eject_m2, busy, done, short, owed,
//                                 to, stock_m1, stock_m2, state
// Revision    : 1.0 - initial release
// ============================================================================
interface change_dispenser_if;
    logic       req;
    logic [3:0] amount;
    logic       hop_ack;
    logic       refill_m1;
    logic       refill_m2;
    logic       eject_m1;
    logic       eject_m2;
    logic       busy;
    logic       done;
    logic       short;
    logic [3:0] owed;
    logic       to;
    logic [3:0] stock_m1;
    logic [3:0] stock_m2;
    logic [2:0] state;

    modport master (
        output req, amount, hop_ack, refill_m1, refill_m2,
        input  eject_m1, eject_m2, busy, done, short, owed, to,
               stock_m1, stock_m2, state
    );

    modport slave (
        input  req, amount, hop_ack, refill_m1, refill_m2,
        output eject_m1, eject_m2, busy, done, short, owed, to,
               stock_m1, stock_m2, state
    );
endinterface
`default_nettype wire

// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
// Module      : change_dispenser
// Description : Greedy two-tube change payout engine. Latches an amount on
//               req, ejects one coin per hopper handshake (M2 before M1),
//               tracks per-tube stock, reports any unpaid remainder and
//               flags a jammed hopper through a sticky timeout.
// Ports       : clk   - system clock, rising edge
//               reset - synchronous active-high reset
//               bus   - change_dispenser_if.slave (request, hopper handshake,
//                       refills, status and debug state)
// Revision    : 1.0 - initial release
// ============================================================================
module change_dispenser #(
    parameter int VAL_M1     = 1,
    parameter int VAL_M2     = 2,
    parameter int TO_CYCLES  = 16,
    parameter int STOCK_INIT = 0
) (
    input wire                clk,
    input wire                reset,
    change_dispenser_if.slave bus
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_CALC  = 3'd1;
    localparam logic [2:0] c_WAIT  = 3'd2;
    localparam logic [2:0] c_DONE  = 3'd3;
    localparam logic [2:0] c_FAULT = 3'd4;

    localparam int              c_CW         = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
    localparam logic [c_CW-1:0] c_CNT_LAST   = c_CW'(TO_CYCLES - 1);
    localparam logic [3:0]      c_V1         = 4'(VAL_M1);
    localparam logic [3:0]      c_V2         = 4'(VAL_M2);
    localparam logic [3:0]      c_STOCK_INIT = 4'(STOCK_INIT);
    localparam logic [3:0]      c_STOCK_MAX  = 4'hF;

    logic [2:0]      r_state;
    logic [3:0]      r_owed;
    logic [c_CW-1:0] r_cnt;
    logic            r_tube_m2;   // tube of the coin currently awaiting ack
    logic [3:0]      r_stock_m1;
    logic [3:0]      r_stock_m2;
    logic            r_eject_m1;
    logic            r_eject_m2;
    logic            r_busy;
    logic            r_done;
    logic            r_short;
    logic            r_to;

    logic            w_ack_m1;
    logic            w_ack_m2;
    logic [3:0]      w_stock_m1_nxt;
    logic [3:0]      w_stock_m2_nxt;

    // An ack only counts while a coin is outstanding.
    assign w_ack_m1 = (r_state == c_WAIT) && bus.hop_ack && !r_tube_m2;
    assign w_ack_m2 = (r_state == c_WAIT) && bus.hop_ack &&  r_tube_m2;

    // Refill and ack on the same tube cancel; refill saturates, ack floors at 0.
    always_comb begin
        w_stock_m1_nxt = r_stock_m1;
        if (bus.refill_m1 && !w_ack_m1) begin
            if (r_stock_m1 != c_STOCK_MAX) w_stock_m1_nxt = r_stock_m1 + 4'd1;
        end else if (w_ack_m1 && !bus.refill_m1) begin
            if (r_stock_m1 != 4'd0) w_stock_m1_nxt = r_stock_m1 - 4'd1;
        end
    end

    always_comb begin
        w_stock_m2_nxt = r_stock_m2;
        if (bus.refill_m2 && !w_ack_m2) begin
            if (r_stock_m2 != c_STOCK_MAX) w_stock_m2_nxt = r_stock_m2 + 4'd1;
        end else if (w_ack_m2 && !bus.refill_m2) begin
            if (r_stock_m2 != 4'd0) w_stock_m2_nxt = r_stock_m2 - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_owed     <= 4'd0;
            r_cnt      <= '0;
            r_tube_m2  <= 1'b0;
            r_stock_m1 <= c_STOCK_INIT;
            r_stock_m2 <= c_STOCK_INIT;
            r_eject_m1 <= 1'b0;
            r_eject_m2 <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_short    <= 1'b0;
            r_to       <= 1'b0;
        end else begin
            r_stock_m1 <= w_stock_m1_nxt;
            r_stock_m2 <= w_stock_m2_nxt;
            // Eject and done are single-cycle pulses; only the transitions
            // below raise them.
            r_eject_m1 <= 1'b0;
            r_eject_m2 <= 1'b0;
            r_done     <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    if (bus.req) begin
                        r_owed  <= bus.amount;
                        r_short <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= c_CALC;
                    end
                end

                c_CALC: begin
                    if (r_owed == 4'd0) begin
                        r_done  <= 1'b1;
                        r_state <= c_DONE;
                    end else if ((r_owed >= c_V2) && (r_stock_m2 != 4'd0)) begin
                        r_eject_m2 <= 1'b1;
                        r_tube_m2  <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= c_WAIT;
                    end else if ((r_owed >= c_V1) && (r_stock_m1 != 4'd0)) begin
                        r_eject_m1 <= 1'b1;
                        r_tube_m2  <= 1'b0;
                        r_cnt      <= '0;
                        r_state    <= c_WAIT;
                    end else begin
                        r_short <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= c_DONE;
                    end
                end

                c_WAIT: begin
                    // An ack on the final counted cycle still wins over timeout.
                    if (bus.hop_ack) begin
                        r_owed  <= r_owed - (r_tube_m2 ? c_V2 : c_V1);
                        r_cnt   <= '0;
                        r_state <= c_CALC;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_to    <= 1'b1;
                        r_state <= c_FAULT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                c_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end

                c_FAULT: begin
                    // Parked until reset; only the stock path stays live.
                    r_busy <= 1'b1;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.eject_m1 = r_eject_m1;
    assign bus.eject_m2 = r_eject_m2;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.short    = r_short;
    assign bus.owed     = r_owed;
    assign bus.to       = r_to;
    assign bus.stock_m1 = r_stock_m1;
    assign bus.stock_m2 = r_stock_m2;
    assign bus.state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// ============================================================================
// Module      : tb_change_dispenser
// Description : Self-checking bench for change_dispenser. A behavioural
//               payout model predicts every output each cycle; directed
//               scenarios pin literal results, then a randomized run
//               exercises requests, refills, acks, timeouts and resets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_change_dispenser;

    localparam int VAL_M1     = 1;
    localparam int VAL_M2     = 2;
    localparam int TO_CYCLES  = 16;
    localparam int STOCK_INIT = 0;

    localparam int P_IDLE  = 0;
    localparam int P_CALC  = 1;
    localparam int P_WAIT  = 2;
    localparam int P_DONE  = 3;
    localparam int P_FAULT = 4;

    logic clk;
    logic reset;

    change_dispenser_if bus ();

    change_dispenser #(
        .VAL_M1     (VAL_M1),
        .VAL_M2     (VAL_M2),
        .TO_CYCLES  (TO_CYCLES),
        .STOCK_INIT (STOCK_INIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- model
    int m_ph, m_owed, m_s1, m_s2, m_waited, m_tube;
    int m_short, m_to, m_done, m_e1, m_e2, m_busy;
    int m_valid = 0;

    // Greedy choice: 2 = pay an M2, 1 = pay an M1, 0 = cannot pay.
    function automatic int greedy(input int owed, input int s1, input int s2);
        if (owed >= VAL_M2 && s2 > 0) return 2;
        if (owed >= VAL_M1 && s1 > 0) return 1;
        return 0;
    endfunction

    function automatic int clamp15(input int v);
        if (v > 15) return 15;
        if (v < 0)  return 0;
        return v;
    endfunction

    always @(posedge clk) begin : model
        int nph, a1, a2, coin;
        if (reset) begin
            m_ph = P_IDLE; m_owed = 0; m_s1 = STOCK_INIT; m_s2 = STOCK_INIT;
            m_waited = 0; m_tube = 0; m_short = 0; m_to = 0;
            m_done = 0; m_e1 = 0; m_e2 = 0; m_busy = 0; m_valid = 1;
        end else if (m_valid != 0) begin
            a1 = (m_ph == P_WAIT && bus.hop_ack && m_tube == 1) ? 1 : 0;
            a2 = (m_ph == P_WAIT && bus.hop_ack && m_tube == 2) ? 1 : 0;
            nph = m_ph; m_e1 = 0; m_e2 = 0;
            case (m_ph)
                P_IDLE: if (bus.req) begin
                    m_owed = int'(bus.amount); m_short = 0; nph = P_CALC;
                end
                P_CALC: begin
                    coin = greedy(m_owed, m_s1, m_s2);
                    if (m_owed == 0) nph = P_DONE;
                    else if (coin == 0) begin m_short = 1; nph = P_DONE; end
                    else begin
                        m_tube = coin; m_waited = 0; nph = P_WAIT;
                        if (coin == 2) m_e2 = 1; else m_e1 = 1;
                    end
                end
                P_WAIT: begin
                    if (bus.hop_ack) begin
                        m_owed = m_owed - ((m_tube == 2) ? VAL_M2 : VAL_M1);
                        nph = P_CALC;
                    end else begin
                        m_waited = m_waited + 1;
                        if (m_waited >= TO_CYCLES) begin m_to = 1; nph = P_FAULT; end
                    end
                end
                P_DONE:  nph = P_IDLE;
                default: nph = P_FAULT;
            endcase
            m_s1 = clamp15(m_s1 + int'(bus.refill_m1) - a1);
            m_s2 = clamp15(m_s2 + int'(bus.refill_m2) - a2);
            m_done = (nph == P_DONE) ? 1 : 0;
            m_busy = (nph != P_IDLE) ? 1 : 0;
            m_ph = nph;
        end
    end

    // ------------------------------------------------------------- checking
    int n_cmp = 0;
    int n_bad = 0;
    int n_wait = 0;
    int ej_log[$];
    int hop_en = 0, hop_max = 0, hop_dly = -1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock: compare all outputs against the model, log ejects, then
    // default the inputs and run the hopper responder.
    task automatic cyc();
        @(negedge clk);
        if (m_valid != 0) begin
            chk("eject_m1", int'(bus.eject_m1), m_e1);
            chk("eject_m2", int'(bus.eject_m2), m_e2);
            chk("busy",     int'(bus.busy),     m_busy);
            chk("done",     int'(bus.done),     m_done);
            chk("short",    int'(bus.short),    m_short);
            chk("owed",     int'(bus.owed),     m_owed);
            chk("to",       int'(bus.to),       m_to);
            chk("stock_m1", int'(bus.stock_m1), m_s1);
            chk("stock_m2", int'(bus.stock_m2), m_s2);
            chk("state",    int'(bus.state),    m_ph);
        end
        if (bus.eject_m1) ej_log.push_back(1);
        if (bus.eject_m2) ej_log.push_back(2);
        if (bus.state == 3'd2) n_wait++;
        reset = 1'b0;
        bus.req = 1'b0;
        bus.hop_ack = 1'b0;
        bus.refill_m1 = 1'b0;
        bus.refill_m2 = 1'b0;
        if (hop_en != 0 && (bus.eject_m1 || bus.eject_m2))
            hop_dly = $urandom_range(0, hop_max);
        if (hop_dly == 0) bus.hop_ack = 1'b1;
        if (hop_dly >= 0) hop_dly--;
    endtask

    task automatic wait_state(input int s, input int budget, input string nm);
        int k = 0;
        while (int'(bus.state) != s && k < budget) begin
            cyc();
            k++;
        end
        chk(nm, int'(bus.state), s);
    endtask

    task automatic do_reset();
        cyc();
        reset = 1'b1;
        hop_dly = -1;
        cyc();
    endtask

    task automatic refill(input int n1, input int n2);
        for (int i = 0; i < ((n1 > n2) ? n1 : n2); i++) begin
            cyc();
            bus.refill_m1 = (i < n1);
            bus.refill_m2 = (i < n2);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.req = 1'b0;
        bus.amount = 4'd0;
        bus.hop_ack = 1'b0;
        bus.refill_m1 = 1'b0;
        bus.refill_m2 = 1'b0;
        cyc();

        // Reset state
        chk("rst_state", int'(bus.state), 0);
        chk("rst_stock_m1", int'(bus.stock_m1), STOCK_INIT);
        chk("rst_busy", int'(bus.busy), 0);

        // Full greedy payout: 5 from 3/3 -> M2, M2, M1
        hop_en = 1; hop_max = 0;
        refill(3, 3);
        cyc();
        ej_log.delete();
        bus.req = 1'b1; bus.amount = 4'd5;
        wait_state(P_DONE, 40, "greedy_reach_done");
        chk("greedy_done", int'(bus.done), 1);
        chk("greedy_owed", int'(bus.owed), 0);
        chk("greedy_short", int'(bus.short), 0);
        chk("greedy_stock_m1", int'(bus.stock_m1), 2);
        chk("greedy_stock_m2", int'(bus.stock_m2), 1);
        chk("greedy_n_ejects", ej_log.size(), 3);
        if (ej_log.size() == 3) begin
            chk("greedy_ej0", ej_log[0], 2);
            chk("greedy_ej1", ej_log[1], 2);
            chk("greedy_ej2", ej_log[2], 1);
        end

        // Zero amount: done two cycles after the req edge, no eject
        cyc();
        ej_log.delete();
        bus.req = 1'b1; bus.amount = 4'd0;
        cyc();
        chk("zero_calc_state", int'(bus.state), 1);
        chk("zero_busy1", int'(bus.busy), 1);
        chk("zero_done_early", int'(bus.done), 0);
        cyc();
        chk("zero_done", int'(bus.done), 1);
        chk("zero_busy2", int'(bus.busy), 1);
        cyc();
        chk("zero_idle_busy", int'(bus.busy), 0);
        chk("zero_idle_done", int'(bus.done), 0);
        chk("zero_n_ejects", ej_log.size(), 0);

        // hop_ack in IDLE is ignored
        bus.hop_ack = 1'b1;
        cyc();
        cyc();
        chk("idle_ack_stock_m1", int'(bus.stock_m1), 2);
        chk("idle_ack_stock_m2", int'(bus.stock_m2), 1);
        chk("idle_ack_owed", int'(bus.owed), 0);

        // Short payout: stock 1/0, amount 3 -> one M1, owed 2
        do_reset();
        refill(1, 0);
        cyc();
        ej_log.delete();
        bus.req = 1'b1; bus.amount = 4'd3;
        wait_state(P_DONE, 40, "short_reach_done");
        chk("short_flag", int'(bus.short), 1);
        chk("short_owed", int'(bus.owed), 2);
        chk("short_stock_m1", int'(bus.stock_m1), 0);
        chk("short_n_ejects", ej_log.size(), 1);
        if (ej_log.size() == 1) chk("short_ej0", ej_log[0], 1);

        // Timeout: stock_m2 2, amount 4, no ack; req in WAIT and FAULT ignored
        hop_en = 0;
        do_reset();
        refill(0, 2);
        cyc();
        ej_log.delete();
        bus.req = 1'b1; bus.amount = 4'd4;
        wait_state(P_WAIT, 10, "to_reach_wait");
        n_wait = 1;
        bus.req = 1'b1; bus.amount = 4'd9;
        wait_state(P_FAULT, 40, "to_reach_fault");
        chk("to_wait_cycles", n_wait, 16);
        chk("to_flag", int'(bus.to), 1);
        chk("to_owed", int'(bus.owed), 4);
        chk("to_stock_m2", int'(bus.stock_m2), 2);
        chk("to_n_ejects", ej_log.size(), 1);
        bus.req = 1'b1; bus.amount = 4'd1;
        cyc();
        cyc();
        chk("to_req_ignored", int'(bus.state), 4);
        chk("to_busy", int'(bus.busy), 1);
        do_reset();
        chk("to_cleared", int'(bus.to), 0);
        chk("to_idle", int'(bus.state), 0);

        // Reset together with an ack during WAIT
        refill(2, 0);
        cyc();
        bus.req = 1'b1; bus.amount = 4'd1;
        wait_state(P_WAIT, 10, "rstack_reach_wait");
        reset = 1'b1;
        bus.hop_ack = 1'b1;
        cyc();
        chk("rstack_state", int'(bus.state), 0);
        chk("rstack_stock_m1", int'(bus.stock_m1), STOCK_INIT);
        chk("rstack_owed", int'(bus.owed), 0);
        chk("rstack_ej", int'(bus.eject_m1), 0);

        // Refill and ack on M2 in the same cycle
        refill(0, 2);
        cyc();
        bus.req = 1'b1; bus.amount = 4'd2;
        wait_state(P_WAIT, 10, "contend_reach_wait");
        bus.hop_ack = 1'b1;
        bus.refill_m2 = 1'b1;
        cyc();
        chk("contend_stock_m2", int'(bus.stock_m2), 2);
        chk("contend_owed", int'(bus.owed), 0);

        // Saturation
        do_reset();
        refill(20, 0);
        cyc();
        chk("sat_stock_m1", int'(bus.stock_m1), 15);

        // Randomized run against the model
        hop_en = 1; hop_max = 3;
        for (int i = 0; i < 4000; i++) begin
            cyc();
            bus.amount = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) bus.req = 1'b1;
            bus.refill_m1 = ($urandom_range(0, 4) == 0);
            bus.refill_m2 = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 11) == 0) bus.hop_ack = 1'b1;
            if ($urandom_range(0, 49) == 0)
                hop_max = ($urandom_range(0, 3) == 0) ? 20 : 3;
            if ((bus.state == 3'd4) ? ($urandom_range(0, 19) == 0)
                                    : ($urandom_range(0, 299) == 0)) begin
                reset = 1'b1;
                hop_dly = -1;
            end
        end
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
